sra_arbiter: RTL and testbench

- Shares one Simple Register Access slave between NUM_M register-access masters.
- Round-robin grant, one transaction outstanding at a time.
- Request (M->S) and response (S->M) streams are fully registered.
- A response timeout returns an error response so a dead slave cannot hang a master. The block sits between control-plane masters (CPU bridge, debug port, sequencers) and a shared register bank.

---
 rtl/sra_arbiter.sv | 155 +++++++++++++++
 tb/tb_sra_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sra_arbiter.sv
// sra_arbiter: round-robin arbiter sharing one SRA slave among NUM_M masters.
// Ports: clk/rst, per-master m_req_*/m_rsp_*, slave s_req_*/s_rsp_*,
// status outputs grant, busy and timeout_cnt.
module sra_arbiter #(
  parameter int NUM_M            = 2,
  parameter int DATA_WIDTH_BYTES = 4,
  parameter int ADDR_WIDTH       = 8,
  parameter int M_USER_BITS      = 2,
  parameter int S_USER_BITS      = 2,
  parameter int TIMEOUT          = 256,
  localparam int DW = 8 * DATA_WIDTH_BYTES,
  localparam int MU = M_USER_BITS + ADDR_WIDTH,
  localparam int SU = S_USER_BITS + ADDR_WIDTH,
  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    m_req_valid,
  output logic [NUM_M-1:0]    m_req_ready,
  input  logic [NUM_M*DW-1:0] m_req_data,
  input  logic [NUM_M*MU-1:0] m_req_user,
  output logic [NUM_M-1:0]    m_rsp_valid,
  input  logic [NUM_M-1:0]    m_rsp_ready,
  output logic [DW-1:0]       m_rsp_data,
  output logic [SU-1:0]       m_rsp_user,
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [DW-1:0]       s_req_data,
  output logic [MU-1:0]       s_req_user,
  input  logic                s_rsp_valid,
  output logic                s_rsp_ready,
  input  logic [DW-1:0]       s_rsp_data,
  input  logic [SU-1:0]       s_rsp_user,
  output logic [GW-1:0]       grant,
  output logic                busy,
  output logic [15:0]         timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    RET
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   pick;
  logic            found;
  logic [31:0]     timer;
  logic            to_hit;
  logic [DW-1:0]   req_data_q;
  logic [MU-1:0]   req_user_q;
  logic [DW-1:0]   rsp_data_q;
  logic [SU-1:0]   rsp_user_q;

  // Search starts one past the last served master and wraps.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = (int'(last_grant) + k) % NUM_M;
      if (!found && m_req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign to_hit = (TIMEOUT != 0) &&
                  (timer == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (found) state_nxt = REQ;
      REQ:  if (s_req_ready) state_nxt = RSP;
      RSP:  if (s_rsp_valid || to_hit) state_nxt = RET;
      RET:  if (m_rsp_ready[grant]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= GW'(NUM_M - 1);
      grant       <= '0;
      timer       <= '0;
      timeout_cnt <= '0;
      req_data_q  <= '0;
      req_user_q  <= '0;
      rsp_data_q  <= '0;
      rsp_user_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant      <= pick;
            req_data_q <= m_req_data[pick*DW +: DW];
            req_user_q <= m_req_user[pick*MU +: MU];
          end
        end
        REQ: begin
          if (s_req_ready) timer <= '0;
        end
        RSP: begin
          timer <= timer + 32'd1;
          // A real reply on the deadline cycle beats the timeout.
          if (s_rsp_valid) begin
            rsp_data_q <= s_rsp_data;
            rsp_user_q <= s_rsp_user;
          end else if (to_hit) begin
            rsp_data_q <= '0;
            rsp_user_q <= {{S_USER_BITS{1'b1}},
                           req_user_q[ADDR_WIDTH-1:0]};
            if (timeout_cnt != 16'hFFFF)
              timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        RET: begin
          if (m_rsp_ready[grant]) last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

  // Slave replies are drained outside RET so late beats
  // after a timeout never stall the bus; only RSP keeps them.
  always_comb begin
    m_req_ready = '0;
    m_rsp_valid = '0;
    if (!rst && state == IDLE && found)
      m_req_ready[pick] = 1'b1;
    if (state == RET)
      m_rsp_valid[grant] = 1'b1;
    s_req_valid = (state == REQ);
    s_rsp_ready = !rst && (state != RET);
    busy        = (state != IDLE);
  end

  assign s_req_data = req_data_q;
  assign s_req_user = req_user_q;
  assign m_rsp_data = rsp_data_q;
  assign m_rsp_user = rsp_user_q;

endmodule

// File: tb/tb_sra_arbiter.sv
// tb_sra_arbiter: directed bench for sra_arbiter.
// Table of single transactions plus timeout/reset/fairness sequences.
module tb_sra_arbiter;

  localparam int NM = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    m_req_valid = '0;
  logic [1:0]    m_req_ready;
  logic [63:0]   m_req_data = '0;
  logic [19:0]   m_req_user = '0;
  logic [1:0]    m_rsp_valid;
  logic [1:0]    m_rsp_ready = '0;
  logic [31:0]   m_rsp_data;
  logic [9:0]    m_rsp_user;
  logic          s_req_valid;
  logic          s_req_ready = 1'b0;
  logic [31:0]   s_req_data;
  logic [9:0]    s_req_user;
  logic          s_rsp_valid = 1'b0;
  logic          s_rsp_ready;
  logic [31:0]   s_rsp_data = '0;
  logic [9:0]    s_rsp_user = '0;
  logic          grant;
  logic          busy;
  logic [15:0]   timeout_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sra_arbiter #(
    .NUM_M(NM), .DATA_WIDTH_BYTES(4), .ADDR_WIDTH(8),
    .M_USER_BITS(2), .S_USER_BITS(2), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_data(m_req_data), .m_req_user(m_req_user),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_data(m_rsp_data), .m_rsp_user(m_rsp_user),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_data(s_req_data), .s_req_user(s_req_user),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_rsp_data(s_rsp_data), .s_rsp_user(s_rsp_user),
    .grant(grant), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          m;
    logic [7:0]  addr;
    logic [1:0]  muser;
    logic [31:0] wdata;
    int          sreq_wait;
    int          lat;
    logic [31:0] rdata;
    logic [9:0]  ruser;
    int          mrsp_wait;
  } vec_t;

  task automatic txn(input vec_t v);
    logic [1:0] oh;
    oh = '0;
    oh[v.m] = 1'b1;
    @(negedge clk);
    m_req_valid = oh;
    m_req_data[v.m*32 +: 32] = v.wdata;
    m_req_user[v.m*10 +: 10] = {v.muser, v.addr};
    #1 chk("m_req_ready", m_req_ready, oh);
    @(negedge clk);
    m_req_valid = '0;
    #1;
    chk("s_req_valid", s_req_valid, 1);
    chk("s_req_data", s_req_data, v.wdata);
    chk("s_req_user", s_req_user, {v.muser, v.addr});
    chk("grant", grant, v.m);
    chk("busy_req", busy, 1);
    repeat (v.sreq_wait) begin
      @(negedge clk); #1;
      chk("s_req_hold", s_req_valid, 1);
      chk("s_req_data_hold", s_req_data, v.wdata);
      chk("busy_hold", busy, 1);
    end
    s_req_ready = 1'b1;
    @(negedge clk);
    s_req_ready = 1'b0;
    #1;
    chk("s_req_done", s_req_valid, 0);
    chk("s_rsp_ready", s_rsp_ready, 1);
    repeat (v.lat) @(negedge clk);
    s_rsp_valid = 1'b1;
    s_rsp_data  = v.rdata;
    s_rsp_user  = v.ruser;
    @(negedge clk);
    s_rsp_valid = 1'b0;
    #1;
    chk("m_rsp_valid", m_rsp_valid, oh);
    chk("m_rsp_data", m_rsp_data, v.rdata);
    chk("m_rsp_user", m_rsp_user, v.ruser);
    repeat (v.mrsp_wait) begin
      m_rsp_ready = ~oh;
      @(negedge clk); #1;
      chk("m_rsp_hold", m_rsp_valid, oh);
      chk("m_rsp_data_hold", m_rsp_data, v.rdata);
      chk("busy_ret", busy, 1);
    end
    m_rsp_ready = oh;
    @(negedge clk);
    m_rsp_ready = '0;
    #1;
    chk("busy_idle", busy, 0);
    chk("m_rsp_clear", m_rsp_valid, 0);
  endtask

  vec_t tbl[4];

  initial begin
    int n;
    tbl[0] = '{0, 8'h10, 2'd2, 32'hA5A5A5A5, 0, 0,
               32'h0, 10'h010, 0};
    tbl[1] = '{1, 8'h3C, 2'd1, 32'h12345678, 0, 2,
               32'hCAFEF00D, 10'h13C, 0};
    tbl[2] = '{0, 8'hFF, 2'd3, 32'hFFFFFFFF, 5, 1,
               32'h0BADBEEF, 10'h2FF, 3};
    // Reply lands exactly when the timer reaches TIMEOUT-1.
    tbl[3] = '{1, 8'h00, 2'd0, 32'h0, 0, TO - 1,
               32'h5555AAAA, 10'h300, 0};

    m_req_valid = 2'b11;
    #2;
    chk("rst_m_req_ready", m_req_ready, 0);
    chk("rst_s_rsp_ready", s_rsp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_tcnt", timeout_cnt, 0);
    chk("rst_s_req_valid", s_req_valid, 0);
    m_req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) txn(tbl[i]);
    chk("tcnt_deadline", timeout_cnt, 0);

    // Timeout: slave never answers.
    @(negedge clk);
    m_req_valid = 2'b01;
    m_req_data[31:0] = 32'h11112222;
    m_req_user[9:0]  = {2'b01, 8'h42};
    @(negedge clk);
    m_req_valid = '0;
    s_req_ready = 1'b1;
    @(negedge clk);
    s_req_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1 chk("to_wait", m_rsp_valid, 0);
      @(negedge clk);
    end
    #1;
    chk("to_valid", m_rsp_valid, 2'b01);
    chk("to_data", m_rsp_data, 0);
    chk("to_user", m_rsp_user, {2'b11, 8'h42});
    chk("to_cnt", timeout_cnt, 1);
    m_rsp_ready = 2'b01;
    @(negedge clk);
    m_rsp_ready = '0;
    s_rsp_valid = 1'b1;
    s_rsp_data  = 32'hDEADBEEF;
    s_rsp_user  = 10'h042;
    #1 chk("stale_ready", s_rsp_ready, 1);
    @(negedge clk);
    s_rsp_valid = 1'b0;
    #1;
    chk("stale_no_fwd", m_rsp_valid, 0);
    chk("stale_busy", busy, 0);
    chk("stale_data", m_rsp_data, 0);

    // Reset while waiting in RSP.
    m_req_valid = 2'b10;
    m_req_data[63:32] = 32'h77778888;
    @(negedge clk);
    m_req_valid = '0;
    s_req_ready = 1'b1;
    @(negedge clk);
    s_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_s_rsp_ready", s_rsp_ready, 0);
    chk("mid_s_req_data", s_req_data, 0);
    chk("mid_tcnt", timeout_cnt, 0);
    chk("mid_grant", grant, 0);
    @(negedge clk);
    rst = 1'b0;

    // Both masters request continuously: strict alternation.
    m_req_valid = 2'b11;
    s_req_ready = 1'b1;
    s_rsp_valid = 1'b1;
    s_rsp_data  = 32'h0;
    s_rsp_user  = '0;
    m_rsp_ready = 2'b11;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      #1;
      if (m_req_ready != 2'b00) begin
        chk("rr_grant", m_req_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
        n++;
      end
      @(negedge clk);
    end
    chk("rr_count", n, 6);
    m_req_valid = '0;
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b0;
    m_rsp_ready = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
